// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-subtractor state encoding, default width
// and a sign-extension helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int unsigned ARITH_W = 8;
    localparam int unsigned SEXT_W  = 64;

    // Sign-extend the low w bits of x across the whole word; callers truncate
    // to w+1 bits to get a one-bit sign extension.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                               input int unsigned       w);
        int unsigned sh;
        sh = SEXT_W - w;
        return $unsigned($signed(x << sh) >>> sh);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flop; the carry presets to 1 so that
// adding the inverted subtrahend forms a two's-complement subtraction.
module serial_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s_c
);

    logic carry;
    logic cout_c;

    assign s_c    = a ^ b ^ carry;
    assign cout_c = (a & b) | (a & carry) | (b & carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b1;
        end else if (load) begin
            carry <= 1'b1;
        end else if (en) begin
            carry <= cout_c;
        end
    end

endmodule

// File: rtl/sub_signed_serial.sv
// Bit-serial signed subtractor: o = a - b at WIDTH+1 bits, one result bit per
// clock, with valid/ready handshakes on both sides.
module sub_signed_serial
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    sub_state_t    state;
    sub_state_t    state_next;
    logic          load;
    logic          step;
    logic          sum_c;
    logic [RW-1:0] a_sr;
    logic [RW-1:0] nb_sr;
    logic [CW-1:0] cnt;

    assign in_ready = rst_n & (state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    serial_fa_cell u_fa (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (step),
        .a     (a_sr[0]),
        .b     (nb_sr[0]),
        .s_c   (sum_c)
    );

    // Operand/result shift registers; sum bits enter at the MSB and walk down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr      <= '0;
            nb_sr     <= '0;
            o         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            if (load) begin
                a_sr  <= RW'(sext(SEXT_W'(a), WIDTH));
                nb_sr <= ~RW'(sext(SEXT_W'(b), WIDTH));
                cnt   <= '0;
            end else if (step) begin
                a_sr  <= {1'b0, a_sr[RW-1:1]};
                nb_sr <= {1'b0, nb_sr[RW-1:1]};
                o     <= {sum_c, o[RW-1:1]};
                cnt   <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sub_signed_serial.sv
// Self-checking bench for sub_signed_serial against an integer-arithmetic model.
module tb_sub_signed_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   o;

    int vectors = 0;
    int errors  = 0;

    sub_signed_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_sub(input int x, input int y);
        return (W+1)'(x - y);
    endfunction

    function automatic int rand_operand();
        int corners[5] = '{-128, -1, 0, 1, 127};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Present operands until accepted; returns at the sample point after the accept edge
    task automatic start_op(input int x, input int y);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) begin
            vectors++; errors++;
            $display("FAIL start_op: in_ready never rose (got %b, want 1)", in_ready);
        end
        a = W'(x);
        b = W'(y);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (o !== '0) begin errors++; $display("FAIL reset_o: got %h want 000", o); end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        start_op(5, 3);
        wait_valid(lat);
        vectors++;
        if (lat != W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
        vectors++;
        if (o !== 9'h002) begin errors++; $display("FAIL basic_o: got %h want 002", o); end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        vectors++;
        if (o !== 9'h002) begin errors++; $display("FAIL basic_o_hold: got %h want 002", o); end
    endtask

    task automatic test_corners();
        int xs[3] = '{-128, 127, -128};
        int ys[3] = '{127, -128, -128};
        logic [W:0] want[3] = '{9'h101, 9'h0FF, 9'h000};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(xs[i], ys[i]);
            wait_valid(lat);
            vectors++;
            if (o !== want[i] || ref_sub(xs[i], ys[i]) !== want[i]) begin
                errors++;
                $display("FAIL corner_%0d: got %h want %h", i, o, want[i]);
            end
            vectors++;
            if (lat != W + 1) begin errors++; $display("FAIL corner_lat_%0d: got %0d want %0d", i, lat, W + 1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W:0] held;
        out_ready = 1'b0;
        start_op(-1, 1);
        wait_valid(lat);
        vectors++;
        if (o !== 9'h1FE) begin errors++; $display("FAIL bp_o: got %h want 1fe", o); end
        held = 9'h1FE;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || o !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b o=%h in_ready=%b want 1 %h 0", i, out_valid, o, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || o !== held) begin
            errors++;
            $display("FAIL bp_release: got valid=%b in_ready=%b o=%h want 0 1 %h", out_valid, in_ready, o, held);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        start_op(100, -27);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (o !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got o=%h valid=%b in_ready=%b want 000 0 1", o, out_valid, in_ready);
        end
        start_op(10, 20);
        wait_valid(lat);
        vectors++;
        if (o !== 9'h1F6 || lat != W + 1) begin
            errors++;
            $display("FAIL reset_mid_next: got o=%h lat=%0d want 1f6 %0d", o, lat, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        out_ready = 1'b1;
        start_op(37, -90);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid(lat);
        vectors++;
        if (o !== ref_sub(37, -90) || lat != W + 1 - 5) begin
            errors++;
            $display("FAIL ignore_in_valid: got o=%h lat=%0d want %h %0d", o, lat, ref_sub(37, -90), W + 1 - 5);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        int last = -1;
        int nacc = 0;
        int x;
        int y;
        bit acc;
        logic [W:0] exp_v;
        out_ready = 1'b1;
        x = rand_operand(); y = rand_operand();
        a = W'(x); b = W'(y);
        in_valid = 1'b1;
        for (int t = 0; t < 70; t++) begin
            if (t == 60) in_valid = 1'b0;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 'x;
                vectors++;
                if (o !== exp_v) begin errors++; $display("FAIL b2b_o at t=%0d: got %h want %h", t, o, exp_v); end
            end
            if (acc) begin
                q.push_back(ref_sub(x, y));
                if (last >= 0) begin
                    vectors++;
                    if (t - last != W + 3) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d want %0d", t - last, W + 3);
                    end
                end
                last = t;
                nacc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                x = rand_operand(); y = rand_operand();
                a = W'(x); b = W'(y);
            end
        end
        vectors++;
        if (nacc != 6 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got accepts=%0d pending=%0d want 6 0", nacc, q.size());
        end
    endtask

    task automatic test_random();
        int lat;
        int x;
        int y;
        int guard;
        for (int i = 0; i < 2500; i++) begin
            x = rand_operand();
            y = rand_operand();
            out_ready = 1'($urandom_range(0, 1));
            start_op(x, y);
            wait_valid(lat);
            vectors++;
            if (o !== ref_sub(x, y) || lat != W + 1) begin
                errors++;
                $display("FAIL random a=%0d b=%0d: got o=%h lat=%0d want %h %0d", x, y, o, lat, ref_sub(x, y), W + 1);
            end
            guard = 0;
            while (out_valid === 1'b1 && guard < 100) begin
                out_ready = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (out_valid === 1'b1 && o !== ref_sub(x, y)) begin
                    vectors++; errors++;
                    $display("FAIL random_hold a=%0d b=%0d: got %h want %h", x, y, o, ref_sub(x, y));
                end
                guard++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_ignore_in_valid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
